// File: rtl/rs_frame_pkg.sv
// Shared types and defaults for the RS frame assembler.
// State encoding is fixed so that debug probes of older designs stay meaningful.
package rs_frame_pkg;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_COLLECT  = 2'd1,
      S_WAIT_DEC = 2'd2
   } state_t;

   localparam int FRAME_LEN_RS = 204;
   localparam int DATA_W_DEF   = 8;

endpackage

// File: rtl/rs_frame_assembler_fifo.sv
// Synchronous first-word-fall-through FIFO; dout shows the head while not empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              wr_en;
   logic              rd_en;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rs_frame_assembler.sv
// Cuts a UART byte stream into FRAME_LEN codewords for the RS decoder; 2-cycle rx-to-dec_ce latency.
// Frames are held off while the decoder works; bytes arriving on a full FIFO are dropped and flagged.
module rs_frame_assembler
   import rs_frame_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int FRAME_LEN   = FRAME_LEN_RS,
   parameter int FIFO_DEPTH  = 16,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              dec_done,
   output logic [DATA_W-1:0] dec_data,
   output logic              dec_ce,
   output logic              dec_sof,
   output logic              dec_eof,
   output logic              busy,
   output logic              frame_err,
   output logic              overflow,
   output logic [15:0]       frame_cnt
);

   localparam int IDX_W = $clog2(FRAME_LEN);
   localparam int TW    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
   localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYC - 1);

   state_t            state;
   state_t            next_state;
   logic              rx_valid_q;
   logic              push;
   logic              pop;
   logic              abort;
   logic              cnt_inc;
   logic [IDX_W-1:0]  byte_idx;
   logic [IDX_W-1:0]  idx_next;
   logic [TW-1:0]     idle_cnt;
   logic [TW-1:0]     idle_next;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;

   // One byte per rising edge of the receiver's level-style valid.
   assign push = rx_valid & ~rx_valid_q;
   assign busy = (state != S_IDLE);

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (rx_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      pop        = 1'b0;
      abort      = 1'b0;
      cnt_inc    = 1'b0;
      idx_next   = byte_idx;
      idle_next  = '0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               idx_next   = IDX_W'(1);
               next_state = S_COLLECT;
            end
         end
         S_COLLECT: begin
            // A pop in the timeout cycle keeps the frame alive.
            if (!fifo_empty) begin
               pop = 1'b1;
               if (byte_idx == LAST_IDX) begin
                  idx_next   = '0;
                  next_state = S_WAIT_DEC;
               end else begin
                  idx_next = byte_idx + IDX_W'(1);
               end
            end else if (idle_cnt == TMO_LAST) begin
               abort      = 1'b1;
               idx_next   = '0;
               next_state = S_IDLE;
            end else begin
               idle_next = idle_cnt + TW'(1);
            end
         end
         S_WAIT_DEC: begin
            if (dec_done) begin
               cnt_inc    = 1'b1;
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_valid_q <= 1'b0;
         byte_idx   <= '0;
         idle_cnt   <= '0;
         dec_data   <= '0;
         dec_ce     <= 1'b0;
         dec_sof    <= 1'b0;
         dec_eof    <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         rx_valid_q <= rx_valid;
         byte_idx   <= idx_next;
         idle_cnt   <= idle_next;
         dec_ce     <= pop;
         dec_sof    <= pop & (byte_idx == '0);
         dec_eof    <= pop & (byte_idx == LAST_IDX);
         frame_err  <= abort;
         overflow   <= push & fifo_full & ~pop;
         if (pop) begin
            dec_data <= fifo_dout;
         end
         if (cnt_inc) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_rs_frame_assembler.sv
// Bench for rs_frame_assembler with FRAME_LEN=4, FIFO_DEPTH=4, TIMEOUT_CYC=8.
// Directed table, hand-written corner sequences and a randomized run against a queue-based model.
module tb_rs_frame_assembler;

   localparam int FL    = 4;
   localparam int DEPTH = 4;
   localparam int TMO   = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        dec_done;
   logic [7:0]  dec_data;
   logic        dec_ce;
   logic        dec_sof;
   logic        dec_eof;
   logic        busy;
   logic        frame_err;
   logic        overflow;
   logic [15:0] frame_cnt;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   rs_frame_assembler #(
      .DATA_W      (8),
      .FRAME_LEN   (FL),
      .FIFO_DEPTH  (DEPTH),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .dec_done  (dec_done),
      .dec_data  (dec_data),
      .dec_ce    (dec_ce),
      .dec_sof   (dec_sof),
      .dec_eof   (dec_eof),
      .busy      (busy),
      .frame_err (frame_err),
      .overflow  (overflow),
      .frame_cnt (frame_cnt)
   );

   // Reference model: byte queue, position within frame, waiting flag, quiet-cycle count.
   logic [7:0]  m_q[$];
   int          m_pos;
   bit          m_wait;
   int          m_quiet;
   bit          m_prev;
   logic [15:0] m_cnt;
   bit          e_ce, e_sof, e_eof, e_err, e_ovf;
   logic [7:0]  e_data;

   task automatic model_reset();
      m_q.delete();
      m_pos = 0; m_wait = 0; m_quiet = 0; m_prev = 0; m_cnt = 16'd0;
      e_ce = 0; e_sof = 0; e_eof = 0; e_err = 0; e_ovf = 0; e_data = 8'h00;
   endtask

   task automatic model_edge();
      bit new_byte;
      bit take;
      new_byte = rx_valid && !m_prev;
      take     = !m_wait && (m_q.size() > 0);
      e_ce  = take;
      e_sof = take && (m_pos == 0);
      e_eof = take && (m_pos == FL - 1);
      e_ovf = new_byte && (m_q.size() == DEPTH) && !take;
      e_err = 0;
      if (take) begin
         e_data  = m_q.pop_front();
         m_quiet = 0;
         if (m_pos == FL - 1) begin
            m_pos  = 0;
            m_wait = 1;
         end else begin
            m_pos++;
         end
      end else if (m_wait) begin
         if (dec_done) begin
            m_wait = 0;
            m_cnt  = m_cnt + 16'd1;
         end
      end else if (m_pos > 0) begin
         m_quiet++;
         if (m_quiet == TMO) begin
            e_err   = 1;
            m_pos   = 0;
            m_quiet = 0;
         end
      end
      if (new_byte && !e_ovf) m_q.push_back(rx_data);
      m_prev = rx_valid;
   endtask

   function automatic logic [29:0] act_vec();
      return {dec_ce, dec_sof, dec_eof, frame_err, overflow, busy, frame_cnt,
              dec_ce ? dec_data : 8'h00};
   endfunction

   function automatic logic [29:0] exp_vec();
      return {e_ce, e_sof, e_eof, e_err, e_ovf, (m_wait || m_pos > 0), m_cnt,
              e_ce ? e_data : 8'h00};
   endfunction

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic rv, input logic [7:0] rd, input logic dd);
      rx_valid = rv;
      rx_data  = rd;
      dec_done = dd;
      model_edge();
      @(posedge clk);
      #1;
      cmp("model", 64'(act_vec()), 64'(exp_vec()));
   endtask

   typedef struct {
      logic        rv;
      logic [7:0]  rd;
      logic        dd;
      logic        ce;
      logic [7:0]  data;
      logic        sof;
      logic        eof;
      logic        bsy;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int         nce;
      int         novf;
      int         nemit;
      logic [7:0] got;
      logic [31:0] emitted;
      logic       first_sof;
      logic       rv;

      tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 16'd0};
      tbl[2]  = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};
      tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 16'd0};
      tbl[4]  = '{1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};
      tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 16'd0};
      tbl[6]  = '{1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};
      tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 16'd0};
      tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'd0};
      tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1};
      tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1};

      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; dec_done = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      cmp("reset_state", 64'(act_vec()), 64'd0);
      cmp("reset_fifo_empty", 64'(dut.u_fifo.empty), 64'd1);
      @(negedge clk);
      reset = 1'b0;

      // Single frame, then decoder completion.
      for (int i = 0; i < 11; i++) begin
         step(tbl[i].rv, tbl[i].rd, tbl[i].dd);
         cmp($sformatf("table[%0d]", i),
             64'({dec_ce, dec_ce ? dec_data : 8'h00, dec_sof, dec_eof, busy, frame_cnt}),
             64'({tbl[i].ce, tbl[i].data, tbl[i].sof, tbl[i].eof, tbl[i].bsy, tbl[i].cnt}));
      end

      // Level held for 10 cycles yields one byte.
      nce = 0; got = 8'h00;
      for (int i = 0; i < 12; i++) begin
         step(i < 10, 8'hA5, 1'b0);
         if (dec_ce) begin nce++; got = dec_data; end
      end
      cmp("hold_ce_count", 64'(nce), 64'd1);
      cmp("hold_data", 64'(got), 64'hA5);
      repeat (6) step(1'b0, 8'h00, 1'b0);

      // Two bytes then silence: abort after TMO quiet cycles.
      step(1'b1, 8'hB1, 1'b0); step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'hB2, 1'b0); step(1'b0, 8'h00, 1'b0);
      repeat (TMO - 1) step(1'b0, 8'h00, 1'b0);
      cmp("tmo_before", 64'({frame_err, busy}), 64'b01);
      step(1'b0, 8'h00, 1'b0);
      cmp("tmo_abort", 64'({frame_err, busy}), 64'b10);
      step(1'b0, 8'h00, 1'b0);
      cmp("tmo_pulse_end", 64'(frame_err), 64'd0);
      step(1'b1, 8'hC0, 1'b0); step(1'b0, 8'h00, 1'b0);
      cmp("tmo_next_sof", 64'({dec_ce, dec_sof, dec_data}), 64'({1'b1, 1'b1, 8'hC0}));
      for (int k = 1; k < FL; k++) begin
         step(1'b1, 8'hC0 + 8'(k), 1'b0); step(1'b0, 8'h00, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0);

      // Six bytes into a 4-deep FIFO while the decoder is busy.
      novf = 0;
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 8'hD0 + 8'(k), 1'b0); if (overflow) novf++;
         step(1'b0, 8'h00, 1'b0);         if (overflow) novf++;
      end
      cmp("ovf_count", 64'(novf), 64'd2);
      cmp("ovf_still_waiting", 64'({busy, dec_ce}), 64'b10);
      step(1'b0, 8'h00, 1'b1);
      nemit = 0; emitted = 32'h0; first_sof = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 8'h00, 1'b0);
         if (dec_ce) begin
            if (nemit == 0) first_sof = dec_sof;
            emitted = {emitted[23:0], dec_data};
            nemit++;
         end
      end
      cmp("drain_count", 64'(nemit), 64'd4);
      cmp("drain_order", 64'(emitted), 64'hD0D1D2D3);
      cmp("drain_first_sof", 64'(first_sof), 64'd1);

      // Push coinciding with dec_done becomes the next sof.
      step(1'b1, 8'h5C, 1'b1);
      cmp("pd_after_done", 64'({dec_ce, busy, frame_cnt}), 64'({1'b0, 1'b0, 16'd3}));
      step(1'b0, 8'h00, 1'b0);
      cmp("pd_sof", 64'({dec_ce, dec_sof, dec_data}), 64'({1'b1, 1'b1, 8'h5C}));

      // Asynchronous reset mid-frame with a byte pending.
      step(1'b1, 8'h71, 1'b0); step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h72, 1'b0);
      #2;
      reset = 1'b1; rx_valid = 1'b0;
      #1;
      cmp("rst_outputs", 64'(act_vec()), 64'd0);
      cmp("rst_fifo_empty", 64'(dut.u_fifo.empty), 64'd1);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      step(1'b1, 8'h81, 1'b0); step(1'b0, 8'h00, 1'b0);
      cmp("rst_next_sof", 64'({dec_ce, dec_sof, dec_data}), 64'({1'b1, 1'b1, 8'h81}));

      // Randomized segments: busy traffic, sparse traffic, long quiet spells.
      for (int seg = 0; seg < 30; seg++) begin
         int mode;
         mode = $urandom_range(0, 2);
         for (int c = 0; c < 100; c++) begin
            case (mode)
               0:       rv = 1'($urandom_range(0, 1));
               1:       rv = ($urandom_range(0, 9) == 0);
               default: rv = ($urandom_range(0, 19) == 0) ? ~rx_valid : rx_valid;
            endcase
            step(rv, 8'($urandom), ($urandom_range(0, 5) == 0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/rs_frame_assembler.md
# rs_frame_assembler

- Parametrised successor to the fixed 204-byte Reed-Solomon input FSM.
- Sits between the UART receiver and the RS decoder:
  - buffers received bytes in a small FIFO;
  - cuts the stream into frames of FRAME_LEN bytes and feeds each byte to the decoder with a one-cycle clock-enable plus start/end-of-frame markers;
  - holds off the next frame until the decoder reports completion.
- Adds inter-byte timeout abort, overflow reporting and a frame counter.

## Interface
- DATA_W, 8, symbol width.
- FRAME_LEN, 204, bytes per codeword (≥2).
- FIFO_DEPTH, 16, input buffer depth (power of 2).
- TIMEOUT_CYC, 100000, idle cycles mid-frame before abort (≥1).
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high; clears all state.
- rx_data  in  DATA_W  receiver byte, valid while rx_valid high.
- rx_valid  in  1  level from receiver; each rising edge = one new byte.
- dec_done  in  1  decoder finished current frame (pulse or level).
- dec_data  out  DATA_W  byte to decoder; reset 0.
- dec_ce  out  1  one-cycle strobe, dec_data valid; reset 0.
- dec_sof  out  1  high with dec_ce on byte 0 of frame; reset 0.
- dec_eof  out  1  high with dec_ce on byte FRAME_LEN-1; reset 0.
- busy  out  1  high in S_COLLECT or S_WAIT_DEC; reset 0.
- frame_err  out  1  one-cycle pulse on timeout abort; reset 0.
- overflow  out  1  one-cycle pulse when a byte is dropped (FIFO full); reset 0.
- frame_cnt  out  16  frames completed (dec_done accepted), wraps at 2^16; reset 0.

## Operation
- Edge detect: rx_valid_q registered; push = rx_valid & ~rx_valid_q. A level held many cycles yields one byte.
- Push writes rx_data into FIFO. If FIFO is full and no pop occurs in the same cycle, the byte is dropped and overflow pulses. Push and pop together when full are legal, with no drop.
- Pop allowed when FIFO is not empty and state is S_IDLE or S_COLLECT. Each pop registers dec_data and asserts dec_ce for one cycle.
- byte_idx, width $clog2(FRAME_LEN):
  - counts pops in the current frame;
  - dec_sof = (byte_idx==0);
  - dec_eof = (byte_idx==FRAME_LEN-1);
  - returns to 0 after eof or abort.
- State S_IDLE:
  - a pop moves to S_COLLECT;
  - dec_done is ignored.
- State S_COLLECT:
  - a pop with byte_idx==FRAME_LEN-1 moves to S_WAIT_DEC;
  - the idle timer increments each cycle with no pop and clears on a pop;
  - when the timer reaches TIMEOUT_CYC, frame_err pulses, byte_idx clears, the FIFO is kept, and the state moves to S_IDLE;
  - a pop in the same cycle as the timeout wins, so there is no abort.
- State S_WAIT_DEC:
  - no pops; pushes continue to fill the FIFO;
  - dec_done sampled high increments frame_cnt and moves to S_IDLE;
  - the FIFO content then drains as the next frame.
- Reset mid-frame: everything clears immediately and FIFO content is lost. The decoder must be reset alongside.

## Timing
- rx_valid rises in cycle t: push at edge end of t, FIFO not empty in t+1, pop in t+1, dec_ce high in t+2. Latency is 2 cycles when the FIFO is empty and the state allows pops.
- Back-to-back pops give at most one dec_ce per cycle.
- The eof byte's dec_ce occurs in the cycle after the transition edge to S_WAIT_DEC. The earliest dec_done is accepted in that same cycle.
- dec_done to next sof dec_ce: 2 cycles if the FIFO is not empty.
- frame_err and overflow are registered, one cycle after the causing edge.

## Structure
- Shared package rs_frame_pkg holds:
  - the state encoding (S_IDLE=2'd0, S_COLLECT=2'd1, S_WAIT_DEC=2'd2);
  - the default FRAME_LEN_RS=204;
  - the default DATA_W=8.
- Sub-module sync_fifo, parameters DATA_W and DEPTH:
  - ports: push, pop, din, dout, full, empty;
  - dout is first-word-fall-through;
  - async reset.
- Top contains the edge detect, FSM, byte_idx, idle timer and frame_cnt.

## Test plan
- FRAME_LEN=4: send 0x11,0x22,0x33,0x44 as separate rx_valid pulses → four dec_ce strobes with matching data, sof on 0x11, eof on 0x44, state S_WAIT_DEC. Then dec_done → frame_cnt=1, busy=0.
- Hold rx_valid high for 10 cycles with rx_data=0xA5 → exactly one dec_ce with 0xA5.
- FRAME_LEN=4, TIMEOUT_CYC=8: send 2 bytes, then idle 8 cycles → frame_err pulse, state S_IDLE. The next byte carries sof.
- FIFO_DEPTH=4, in S_WAIT_DEC: send 6 bytes → 2 overflow pulses. dec_done → 4 bytes emitted in order, first with sof.
- In S_WAIT_DEC, push in the same cycle as dec_done → byte retained and emitted as the sof of the next frame, 2 cycles later.
- Assert reset mid-frame after byte 2 → all outputs 0 and FIFO empty at once. The next byte after release carries sof.
